// File: rtl/control_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, RV32I opcodes
// and the datapath mux / ALU-control codes driven by the main FSM.
package control_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        LUI,
        ALUWB,
        BRANCH,
        JALR_ADR,
        JUMP,
        TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [2:0] ALUOP_ADD    = 3'b000;
    localparam logic [2:0] ALUOP_BRANCH = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT  = 3'b010;
    localparam logic [2:0] ALUOP_PASSB  = 3'b100;

endpackage

// File: rtl/imm_src_decoder.sv
// Combinational opcode -> immediate-format select for the immediate extender.
module imm_src_decoder
    import control_pkg::*;
#(
    parameter int OP_WIDTH      = 7,
    parameter int IMM_SRC_WIDTH = 3
) (
    input  logic [OP_WIDTH-1:0]      op,
    output logic [IMM_SRC_WIDTH-1:0] imm_src
);

    always_comb begin
        case (op)
            OP_LOAD, OP_ITYPE, OP_JALR: imm_src = IMM_I;
            OP_STORE:                   imm_src = IMM_S;
            OP_BRANCH:                  imm_src = IMM_B;
            OP_LUI, OP_AUIPC:           imm_src = IMM_U;
            OP_JAL:                     imm_src = IMM_J;
            default:                    imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Multicycle RV32I main control FSM sequencing fetch/decode/execute over a shared ALU
// and one memory port. Define MEM_WAIT_EN to honour MemReady stalls; otherwise memory is single-cycle.
module multicycle_main_fsm
    import control_pkg::*;
#(
    parameter int OP_WIDTH      = 7,
    parameter int IMM_SRC_WIDTH = 3,
    parameter int ALU_OP_WIDTH  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [OP_WIDTH-1:0]      op,
    input  logic                     MemReady,
    output logic                     PCUpdate,
    output logic                     Branch,
    output logic                     Jump,
    output logic                     IRWrite,
    output logic                     AdrSrc,
    output logic                     MemRead,
    output logic                     MemWrite,
    output logic                     RegWrite,
    output logic [1:0]               ALUSrcA,
    output logic [1:0]               ALUSrcB,
    output logic [1:0]               ResultSrc,
    output logic [IMM_SRC_WIDTH-1:0] ImmSrc,
    output logic [ALU_OP_WIDTH-1:0]  ALUOp,
    output logic                     InstrDone,
    output logic                     Illegal
);

    state_t state;
    logic   mem_ready;

`ifdef MEM_WAIT_EN
    assign mem_ready = MemReady;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = MemReady;
    assign mem_ready        = 1'b1;
`endif

    imm_src_decoder #(
        .OP_WIDTH      (OP_WIDTH),
        .IMM_SRC_WIDTH (IMM_SRC_WIDTH)
    ) u_imm_src_decoder (
        .op      (op),
        .imm_src (ImmSrc)
    );

    // NOTE: async reset and next-state share one block; sequential state uses <= only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FETCH;
            Illegal <= 1'b0;
        end else begin
            case (state)
                FETCH:    if (mem_ready) state <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: state <= MEMADR;
                        OP_RTYPE:          state <= EXECUTER;
                        OP_ITYPE:          state <= EXECUTEI;
                        OP_BRANCH:         state <= BRANCH;
                        OP_JAL:            state <= JUMP;
                        OP_JALR:           state <= JALR_ADR;
                        OP_LUI:            state <= LUI;
                        OP_AUIPC:          state <= ALUWB;
                        default: begin
                            state   <= TRAP;
                            Illegal <= 1'b1;
                        end
                    endcase
                end
                MEMADR:   state <= op[5] ? MEMWRITE : MEMREAD;
                MEMREAD:  if (mem_ready) state <= MEMWB;
                MEMWRITE: if (mem_ready) state <= FETCH;
                EXECUTER, EXECUTEI, LUI: state <= ALUWB;
                JALR_ADR: state <= JUMP;
                JUMP:     state <= ALUWB;
                MEMWB, ALUWB, BRANCH: state <= FETCH;
                TRAP:     state <= TRAP;
                default:  state <= FETCH;
            endcase
        end
    end

    // Moore decode plus the MemReady-gated Mealy terms of the memory states.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        PCUpdate  = 1'b0;
        Branch    = 1'b0;
        Jump      = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ResultSrc = RES_ALUOUT;
        ALUOp     = ALUOP_ADD;
        InstrDone = 1'b0;
        case (state)
            FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                PCUpdate  = mem_ready;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            MEMADR, JALR_ADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            MEMREAD: begin
                MemRead = 1'b1;
                AdrSrc  = 1'b1;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            MEMWRITE: begin
                MemWrite  = 1'b1;
                AdrSrc    = 1'b1;
                InstrDone = mem_ready;
            end
            EXECUTER: begin
                ALUSrcA = SRCA_RS1;
                ALUOp   = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
            end
            LUI: begin
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_PASSB;
            end
            ALUWB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            BRANCH: begin
                ALUSrcA   = SRCA_RS1;
                ALUOp     = ALUOP_BRANCH;
                Branch    = 1'b1;
                InstrDone = 1'b1;
            end
            JUMP: begin
                PCUpdate = 1'b1;
                Jump     = 1'b1;
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_FOUR;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm: per-instruction cycle scripts built from
// the instruction latencies and per-step control values, with random MemReady stalls.
module tb_multicycle_main_fsm;

`ifdef MEM_WAIT_EN
    localparam bit MEM_WAIT = 1'b1;
`else
    localparam bit MEM_WAIT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic       MemReady;
    logic       PCUpdate, Branch, Jump, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0] ImmSrc, ALUOp;
    logic       InstrDone, Illegal;

    multicycle_main_fsm dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .MemReady  (MemReady),
        .PCUpdate  (PCUpdate),
        .Branch    (Branch),
        .Jump      (Jump),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ImmSrc    (ImmSrc),
        .ALUOp     (ALUOp),
        .InstrDone (InstrDone),
        .Illegal   (Illegal)
    );

    always #5 clk = ~clk;

    // {PCUpdate,Branch,Jump,IRWrite,AdrSrc,MemRead,MemWrite,RegWrite,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,InstrDone}
    typedef logic [17:0] outs_t;
    typedef struct {
        string tag;
        outs_t go;
        outs_t stall_go;
        bit    waits;
        bit    ill;
    } step_t;

    outs_t   obs;
    step_t   seq_q[$];
    int      n_cmp  = 0;
    int      n_fail = 0;
    outs_t   f_go, f_stall;

    assign obs = {PCUpdate, Branch, Jump, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite,
                  ALUSrcA, ALUSrcB, ResultSrc, ALUOp, InstrDone};

    function automatic outs_t pk(bit pcu, bit br, bit jp, bit irw, bit adr, bit mr, bit mw, bit rw,
                                 logic [1:0] asa, logic [1:0] asb, logic [1:0] rs,
                                 logic [2:0] aop, bit done);
        return {pcu, br, jp, irw, adr, mr, mw, rw, asa, asb, rs, aop, done};
    endfunction

    function automatic logic [2:0] imm_exp(logic [6:0] o);
        case (o)
            7'b0000011, 7'b0010011, 7'b1100111: return 3'b000;
            7'b0100011:                         return 3'b001;
            7'b1100011:                         return 3'b010;
            7'b0110111, 7'b0010111:             return 3'b011;
            7'b1101111:                         return 3'b100;
            default:                            return 3'b000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic add(input string tag, input outs_t g, input outs_t s, input bit w, input bit ill);
        step_t st;
        st.tag = tag; st.go = g; st.stall_go = s; st.waits = w; st.ill = ill;
        seq_q.push_back(st);
    endtask

    // Cycle-by-cycle script of one instruction, straight from the per-state control table.
    task automatic build(input logic [6:0] o);
        outs_t dec, wb, jmp, rsx;
        dec = pk(0,0,0,0,0,0,0,0, 2'b01, 2'b01, 2'b00, 3'b000, 0);
        wb  = pk(0,0,0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'b000, 1);
        jmp = pk(1,0,1,0,0,0,0,0, 2'b01, 2'b10, 2'b00, 3'b000, 0);
        rsx = pk(0,0,0,0,0,0,0,0, 2'b10, 2'b01, 2'b00, 3'b000, 0);
        seq_q.delete();
        add("fetch", f_go, f_stall, 1, 0);
        add("decode", dec, dec, 0, 0);
        case (o)
            7'b0000011: begin
                add("memadr", rsx, rsx, 0, 0);
                add("memread", pk(0,0,0,0,1,1,0,0, 2'b00,2'b00,2'b00,3'b000,0),
                               pk(0,0,0,0,1,1,0,0, 2'b00,2'b00,2'b00,3'b000,0), 1, 0);
                add("memwb", pk(0,0,0,0,0,0,0,1, 2'b00,2'b00,2'b01,3'b000,1),
                             pk(0,0,0,0,0,0,0,1, 2'b00,2'b00,2'b01,3'b000,1), 0, 0);
            end
            7'b0100011: begin
                add("memadr", rsx, rsx, 0, 0);
                add("memwrite", pk(0,0,0,0,1,0,1,0, 2'b00,2'b00,2'b00,3'b000,1),
                                pk(0,0,0,0,1,0,1,0, 2'b00,2'b00,2'b00,3'b000,0), 1, 0);
            end
            7'b0110011: begin
                add("exec_r", pk(0,0,0,0,0,0,0,0, 2'b10,2'b00,2'b00,3'b010,0),
                              pk(0,0,0,0,0,0,0,0, 2'b10,2'b00,2'b00,3'b010,0), 0, 0);
                add("aluwb", wb, wb, 0, 0);
            end
            7'b0010011: begin
                add("exec_i", pk(0,0,0,0,0,0,0,0, 2'b10,2'b01,2'b00,3'b010,0),
                              pk(0,0,0,0,0,0,0,0, 2'b10,2'b01,2'b00,3'b010,0), 0, 0);
                add("aluwb", wb, wb, 0, 0);
            end
            7'b0110111: begin
                add("lui", pk(0,0,0,0,0,0,0,0, 2'b00,2'b01,2'b00,3'b100,0),
                           pk(0,0,0,0,0,0,0,0, 2'b00,2'b01,2'b00,3'b100,0), 0, 0);
                add("aluwb", wb, wb, 0, 0);
            end
            7'b0010111: add("aluwb", wb, wb, 0, 0);
            7'b1100011: add("branch", pk(0,1,0,0,0,0,0,0, 2'b10,2'b00,2'b00,3'b001,1),
                                      pk(0,1,0,0,0,0,0,0, 2'b10,2'b00,2'b00,3'b001,1), 0, 0);
            7'b1101111: begin
                add("jump", jmp, jmp, 0, 0);
                add("aluwb", wb, wb, 0, 0);
            end
            7'b1100111: begin
                add("jalr_adr", rsx, rsx, 0, 0);
                add("jump", jmp, jmp, 0, 0);
                add("aluwb", wb, wb, 0, 0);
            end
            default: begin
                for (int i = 0; i < 20; i++) add("trap", '0, '0, 0, 1);
            end
        endcase
    endtask

    // Called just after a falling edge; stalls<0 means random MemReady on waiting steps.
    task automatic run_seq(input int stalls, input int max_steps);
        int  n;
        bit  eff;
        n = 0;
        foreach (seq_q[k]) begin
            int stalled;
            if (n >= max_steps) break;
            n++;
            stalled = 0;
            forever begin
                if (seq_q[k].waits) begin
                    if (stalls >= 0) MemReady = (stalled >= stalls);
                    else MemReady = (stalled >= 4) || ($urandom_range(0, 2) != 0);
                end else begin
                    MemReady = 1'($urandom_range(0, 1));
                end
                #1;
                eff = MEM_WAIT ? MemReady : 1'b1;
                check({seq_q[k].tag, "/outs"}, 32'(obs),
                      32'((seq_q[k].waits && !eff) ? seq_q[k].stall_go : seq_q[k].go));
                check({seq_q[k].tag, "/immsrc"}, 32'(ImmSrc), 32'(imm_exp(op)));
                check({seq_q[k].tag, "/illegal"}, 32'(Illegal), 32'(seq_q[k].ill));
                @(negedge clk);
                if (!seq_q[k].waits || eff) break;
                stalled++;
            end
        end
    endtask

    task automatic run_instr(input logic [6:0] o, input int stalls);
        op = o;
        build(o);
        run_seq(stalls, 1000);
    endtask

    // Async reset arriving mid-cycle: FETCH values must appear before the next rising edge.
    task automatic pulse_reset(input string tag);
        bit eff;
        #2 rst = 1'b1;
        #1;
        eff = MEM_WAIT ? MemReady : 1'b1;
        check({tag, "/outs"}, 32'(obs), 32'(eff ? f_go : f_stall));
        check({tag, "/illegal"}, 32'(Illegal), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [6:0] legal_ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                                 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    initial begin
        f_go    = pk(1,0,0,1,0,1,0,0, 2'b00, 2'b10, 2'b10, 3'b000, 0);
        f_stall = pk(0,0,0,0,0,1,0,0, 2'b00, 2'b10, 2'b10, 3'b000, 0);
        rst      = 1'b1;
        op       = 7'b0000000;
        MemReady = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        check("reset/outs", 32'(obs), 32'(MEM_WAIT ? f_stall : f_go));
        check("reset/illegal", 32'(Illegal), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed instructions
        run_instr(7'b0000011, 0);
        run_instr(7'b0100011, 3);
        run_instr(7'b1100011, 0);
        run_instr(7'b1100111, 0);
        run_instr(7'b1101111, 2);
        run_instr(7'b0010111, 0);

        // Random instruction stream with random memory stalls
        for (int i = 0; i < 60; i++)
            run_instr(legal_ops[$urandom_range(0, 8)], -1);

        // Reset asserted while lw sits in MEMREAD with memory not ready
        op = 7'b0000011;
        build(op);
        run_seq(0, 3);
        MemReady = 1'b0;
        #1;
        check("memread_pre_rst/outs", 32'(obs),
              32'(pk(0,0,0,0,1,1,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 0)));
        pulse_reset("memread_rst");
        run_instr(7'b0110011, 0);

        // Illegal opcode traps and stays trapped until reset
        run_instr(7'b1111111, 0);
        pulse_reset("trap_rst");
        run_instr(7'b0000011, -1);
        run_instr(7'b0110111, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_main_fsm.md
Name: multicycle_main_fsm

Overview:
Multicycle successor to the single-cycle main decoder. A Moore/Mealy state machine sequences each RV32I instruction over 3–5 cycles through a shared ALU and a single unified memory port. It stalls on a memory-ready handshake and traps on illegal opcodes. It sits in rtl/control_unit and drives the multicycle datapath (PC, OldPC, IR, Data, ALUOut registers), alongside the existing ALU decoder, which consumes ALUOp.

Parameters:
OP_WIDTH, 7, opcode width
IMM_SRC_WIDTH, 3, ImmSrc width (000 I, 001 S, 010 B, 011 U, 100 J)
ALU_OP_WIDTH, 3, ALUOp width (000 add, 001 branch compare, 010 funct-decoded, 100 pass SrcB)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
op  in  OP_WIDTH  opcode from IR
MemReady  in  1  memory completes access this cycle
PCUpdate  out  1  unconditional PC write
Branch  out  1  conditional PC write (datapath gates with compare result)
Jump  out  1  high in JUMP state
IRWrite  out  1  latch instruction (also latches OldPC)
AdrSrc  out  1  memory address: 0 PC, 1 ALUOut
MemRead, MemWrite  out  1 each  memory strobes
RegWrite  out  1  register-file write
ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1
ALUSrcB  out  2  00 rs2, 01 ImmExt, 10 constant 4
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
ImmSrc  out  IMM_SRC_WIDTH  combinational from op (lw/jalr/I-type I, sw S, branch B, lui/auipc U, jal J, else 000)
ALUOp  out  ALU_OP_WIDTH  per state
InstrDone  out  1  one-cycle pulse on an instruction's last cycle
Illegal  out  1  sticky trap flag

Behaviour:
- Reset (async, any state, including mid-instruction) → FETCH; Illegal=0. Outputs immediately take the FETCH values with MemReady gating.
- All outputs not listed for a state are 0.
- FETCH: MemRead=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUOp=000. IRWrite and PCUpdate equal MemReady (Mealy). Go to DECODE when MemReady=1, otherwise hold.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=000, so ALUOut ← OldPC+imm. Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BRANCH
  - 1101111 → JUMP
  - 1100111 → JALR_ADR
  - 0110111 → LUI
  - 0010111 → ALUWB
  - other → TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=000. Go to MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: MemRead=1, AdrSrc=1. Hold while MemReady=0, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, InstrDone=1 → FETCH.
- MEMWRITE: MemWrite=1, AdrSrc=1. Hold while MemReady=0. When MemReady=1, InstrDone=1 and go to FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=010 → ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=010 → ALUWB.
- LUI: ALUSrcB=01, ALUOp=100 → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, InstrDone=1 → FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=001, ResultSrc=00, Branch=1, InstrDone=1 → FETCH.
- JALR_ADR: ALUSrcA=10, ALUSrcB=01, ALUOp=000 → JUMP.
- JUMP: ResultSrc=00, PCUpdate=1, Jump=1, ALUSrcA=01, ALUSrcB=10, ALUOp=000 (ALUOut ← OldPC+4) → ALUWB.
- TRAP: Illegal=1. Absorbing state: all strobes and PC writes stay 0 until rst.
- Memory strobes stay asserted and stable for every stalled cycle.
- Latency with MemReady always 1:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type, I-type, lui: 4 cycles
  - auipc: 3 cycles
  - branch: 3 cycles
  - jal: 4 cycles
  - jalr: 5 cycles

Optional Feature:
MEM_WAIT_EN
- Defined: MemReady stall behaviour as specified above.
- Undefined: MemReady is internally tied to 1 (port kept, ignored); memory is single-cycle and FETCH/MEMREAD/MEMWRITE never hold.

Decomposition:
- Package control_pkg holds:
  - state enum state_t: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, LUI, ALUWB, BRANCH, JALR_ADR, JUMP, TRAP
  - opcode localparams
  - ALUSrcA, ALUSrcB, ResultSrc, ImmSrc and ALUOp encodings
- Sub-module imm_src_decoder: combinational op → ImmSrc.
- The FSM (state register, next-state logic, output logic) stays in one module.

Test Plan:
- lw (op=0000011), MemReady=1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and InstrDone=1 only in cycle 5, ResultSrc=01.
- sw (op=0100011), MemReady=0 for 3 cycles in MEMWRITE (MEM_WAIT_EN) → MemWrite=1 for 4 consecutive cycles, AdrSrc=1, InstrDone on the 4th; RegWrite never 1.
- beq (op=1100011) → 3 cycles; Branch=1, ALUOp=001 in cycle 3; ImmSrc=010 in DECODE.
- jalr (op=1100111) → FETCH, DECODE, JALR_ADR, JUMP, ALUWB; PCUpdate=Jump=1 in cycle 4; RegWrite=1 in cycle 5.
- op=1111111 → TRAP after DECODE; Illegal=1 held for 20 cycles with PCUpdate=IRWrite=0; rst pulse → FETCH, Illegal=0.
- rst asserted asynchronously in MEMREAD mid-stall → FETCH outputs appear before the next clk edge; MemRead switches to AdrSrc=0.
